// File: rtl/wb_regfile_dual_pkg.sv
// Shared constants for the dual-issue write-back stage and register file.
// Optional write-through bypass is enabled by defining WB_BYPASS_EN.
package wb_regfile_dual_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned ADDR_W   = 5;

  localparam int unsigned REG_ZERO = 0;

  localparam logic WB_SEL_MEM = 1'b1;
  localparam logic WB_SEL_ALU = 1'b0;

endpackage

// File: rtl/wb_regfile_dual_sel_slot.sv
// Per-slot write-back mux and effective write enable (r0 and reset masked).
// Cross-slot conflict masking is applied by the parent.
module wb_sel_slot
  import wb_regfile_dual_pkg::*;
#(
  parameter int unsigned DATA_W = wb_regfile_dual_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_regfile_dual_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic              sel,
  input  logic              wr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] wd,
  output logic              we
);

  assign wd = (sel == WB_SEL_MEM) ? mem_data : alu_data;
  assign we = wr && (dest != ADDR_W'(REG_ZERO)) && !rst;

endmodule

// File: rtl/wb_regfile_dual.sv
// Dual-slot write-back stage with a 32x32 register file and four async read ports.
// Define WB_BYPASS_EN to make same-cycle writes visible on the read ports.
module wb_regfile_dual
  import wb_regfile_dual_pkg::*;
#(
  parameter int unsigned DATA_W = wb_regfile_dual_pkg::DATA_W,
  parameter int unsigned NREG   = wb_regfile_dual_pkg::NREG,
  // Must satisfy 2**ADDR_W == NREG.
  parameter int unsigned ADDR_W = wb_regfile_dual_pkg::ADDR_W
) (
  input  logic              reloj,
  input  logic              resetWB,
  input  logic              DIR_WB1,
  input  logic              DIR_WB2,
  input  logic              REG_WR1,
  input  logic              REG_WR2,
  input  logic [DATA_W-1:0] DO_wb1,
  input  logic [DATA_W-1:0] DO_wb2,
  input  logic [DATA_W-1:0] DIR_wb1,
  input  logic [DATA_W-1:0] DIR_wb2,
  input  logic [ADDR_W-1:0] Y_MUX_wb1,
  input  logic [ADDR_W-1:0] Y_MUX_wb2,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RT1,
  input  logic [ADDR_W-1:0] RS2,
  input  logic [ADDR_W-1:0] RT2,
  output logic [DATA_W-1:0] RD_RS1,
  output logic [DATA_W-1:0] RD_RT1,
  output logic [DATA_W-1:0] RD_RS2,
  output logic [DATA_W-1:0] RD_RT2,
  output logic [DATA_W-1:0] WD1,
  output logic [DATA_W-1:0] WD2,
  output logic              WE1_eff,
  output logic              WE2_eff
);

  logic              we1_raw;
  logic              we2_raw;
  logic [DATA_W-1:0] regs [NREG];
  logic [ADDR_W-1:0] raddr [4];
  logic [DATA_W-1:0] rdata [4];

  wb_sel_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_slot1 (
    .rst      (resetWB),
    .sel      (DIR_WB1),
    .wr       (REG_WR1),
    .mem_data (DO_wb1),
    .alu_data (DIR_wb1),
    .dest     (Y_MUX_wb1),
    .wd       (WD1),
    .we       (we1_raw)
  );

  wb_sel_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_slot2 (
    .rst      (resetWB),
    .sel      (DIR_WB2),
    .wr       (REG_WR2),
    .mem_data (DO_wb2),
    .alu_data (DIR_wb2),
    .dest     (Y_MUX_wb2),
    .wd       (WD2),
    .we       (we2_raw)
  );

  // Slot 2 is the younger instruction, so it wins a same-destination clash.
  assign WE2_eff = we2_raw;
  assign WE1_eff = we1_raw && !(we2_raw && (Y_MUX_wb1 == Y_MUX_wb2));

  always_ff @(posedge reloj) begin
    if (resetWB) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (WE1_eff) regs[Y_MUX_wb1] <= WD1;
      if (WE2_eff) regs[Y_MUX_wb2] <= WD2;
    end
  end

  assign raddr[0] = RS1;
  assign raddr[1] = RT1;
  assign raddr[2] = RS2;
  assign raddr[3] = RT2;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rdata[i] = regs[raddr[i]];
`ifdef WB_BYPASS_EN
      // Slot 2 checked last so it takes priority on a double match.
      if (WE1_eff && (raddr[i] == Y_MUX_wb1)) rdata[i] = WD1;
      if (WE2_eff && (raddr[i] == Y_MUX_wb2)) rdata[i] = WD2;
`endif
      if (raddr[i] == ADDR_W'(REG_ZERO)) rdata[i] = '0;
    end
  end

  assign RD_RS1 = rdata[0];
  assign RD_RT1 = rdata[1];
  assign RD_RS2 = rdata[2];
  assign RD_RT2 = rdata[3];

endmodule

// File: tb/tb_wb_regfile_dual.sv
// Self-checking bench for wb_regfile_dual: vector table, scoreboard queue and a
// reference register model; honours WB_BYPASS_EN when it is defined.
module tb_wb_regfile_dual;

  logic        reloj;
  logic        resetWB;
  logic        DIR_WB1, DIR_WB2, REG_WR1, REG_WR2;
  logic [31:0] DO_wb1, DO_wb2, DIR_wb1, DIR_wb2;
  logic [4:0]  Y_MUX_wb1, Y_MUX_wb2, RS1, RT1, RS2, RT2;
  logic [31:0] RD_RS1, RD_RT1, RD_RS2, RD_RT2, WD1, WD2;
  logic        WE1_eff, WE2_eff;

  wb_regfile_dual dut (
    .reloj     (reloj),
    .resetWB   (resetWB),
    .DIR_WB1   (DIR_WB1),
    .DIR_WB2   (DIR_WB2),
    .REG_WR1   (REG_WR1),
    .REG_WR2   (REG_WR2),
    .DO_wb1    (DO_wb1),
    .DO_wb2    (DO_wb2),
    .DIR_wb1   (DIR_wb1),
    .DIR_wb2   (DIR_wb2),
    .Y_MUX_wb1 (Y_MUX_wb1),
    .Y_MUX_wb2 (Y_MUX_wb2),
    .RS1       (RS1),
    .RT1       (RT1),
    .RS2       (RS2),
    .RT2       (RT2),
    .RD_RS1    (RD_RS1),
    .RD_RT1    (RD_RT1),
    .RD_RS2    (RD_RS2),
    .RD_RT2    (RD_RT2),
    .WD1       (WD1),
    .WD2       (WD2),
    .WE1_eff   (WE1_eff),
    .WE2_eff   (WE2_eff)
  );

  typedef struct {
    logic        rst;
    logic        wr1, sel1;
    logic [31:0] mdat1, alu1;
    logic [4:0]  d1;
    logic        wr2, sel2;
    logic [31:0] mdat2, alu2;
    logic [4:0]  d2;
    logic [4:0]  rs1, rt1, rs2, rt2;
    logic [31:0] wd1, wd2;
    logic        we1, we2;
  } vec_t;

  typedef struct packed {
    logic [31:0] r0, r1, r2, r3, wd1, wd2;
    logic        we1, we2;
  } exp_t;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] m [32];
  exp_t        sb [$];
  vec_t        vecs [9];

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst,
                              input logic wr1, input logic sel1, input logic [31:0] mdat1,
                              input logic [31:0] alu1, input logic [4:0] d1,
                              input logic wr2, input logic sel2, input logic [31:0] mdat2,
                              input logic [31:0] alu2, input logic [4:0] d2,
                              input logic [4:0] rs1, input logic [4:0] rt1,
                              input logic [4:0] rs2, input logic [4:0] rt2,
                              input logic [31:0] wd1, input logic [31:0] wd2,
                              input logic we1, input logic we2);
    vec_t v;
    v.rst = rst;
    v.wr1 = wr1; v.sel1 = sel1; v.mdat1 = mdat1; v.alu1 = alu1; v.d1 = d1;
    v.wr2 = wr2; v.sel2 = sel2; v.mdat2 = mdat2; v.alu2 = alu2; v.d2 = d2;
    v.rs1 = rs1; v.rt1 = rt1; v.rs2 = rs2; v.rt2 = rt2;
    v.wd1 = wd1; v.wd2 = wd2; v.we1 = we1; v.we2 = we2;
    return v;
  endfunction

  // Expected write-back outputs straight from the behavioural definition.
  function automatic vec_t calc(input vec_t v);
    vec_t r = v;
    r.wd1 = v.sel1 ? v.mdat1 : v.alu1;
    r.wd2 = v.sel2 ? v.mdat2 : v.alu2;
    r.we2 = v.wr2 && (v.d2 != 5'd0) && !v.rst;
    r.we1 = v.wr1 && (v.d1 != 5'd0) && !v.rst && !(r.we2 && (v.d1 == v.d2));
    return r;
  endfunction

  function automatic logic [31:0] mread(input vec_t v, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
    if (v.we2 && (a == v.d2)) return v.wd2;
    if (v.we1 && (a == v.d1)) return v.wd1;
`endif
    return m[a];
  endfunction

  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge reloj);
    resetWB = v.rst;
    REG_WR1 = v.wr1; DIR_WB1 = v.sel1; DO_wb1 = v.mdat1; DIR_wb1 = v.alu1; Y_MUX_wb1 = v.d1;
    REG_WR2 = v.wr2; DIR_WB2 = v.sel2; DO_wb2 = v.mdat2; DIR_wb2 = v.alu2; Y_MUX_wb2 = v.d2;
    RS1 = v.rs1; RT1 = v.rt1; RS2 = v.rs2; RT2 = v.rt2;
    e.r0 = mread(v, v.rs1);
    e.r1 = mread(v, v.rt1);
    e.r2 = mread(v, v.rs2);
    e.r3 = mread(v, v.rt2);
    e.wd1 = v.wd1; e.wd2 = v.wd2; e.we1 = v.we1; e.we2 = v.we2;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    chk({tag, " WD1"},     WD1,     got.wd1);
    chk({tag, " WD2"},     WD2,     got.wd2);
    chk({tag, " WE1_eff"}, {31'd0, WE1_eff}, {31'd0, got.we1});
    chk({tag, " WE2_eff"}, {31'd0, WE2_eff}, {31'd0, got.we2});
    chk({tag, " RD_RS1"},  RD_RS1,  got.r0);
    chk({tag, " RD_RT1"},  RD_RT1,  got.r1);
    chk({tag, " RD_RS2"},  RD_RS2,  got.r2);
    chk({tag, " RD_RT2"},  RD_RT2,  got.r3);
    @(posedge reloj);
    if (v.rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
    end else begin
      if (v.we1) m[v.d1] = v.wd1;
      if (v.we2) m[v.d2] = v.wd2;
    end
  endtask

  initial begin
    // rst, wr1 sel1 mdat1 alu1 d1, wr2 sel2 mdat2 alu2 d2, rs1 rt1 rs2 rt2, wd1 wd2 we1 we2
    vecs[0] = mk(1, 1, 0, 32'h0, 32'h0000_ABCD, 3, 0, 0, 32'h0, 32'h0, 0,
                 3, 3, 0, 0, 32'h0000_ABCD, 32'h0, 0, 0);
    vecs[1] = mk(0, 1, 0, 32'hCAFE_0000, 32'h0000_1234, 5, 1, 1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 9,
                 5, 9, 5, 9, 32'h0000_1234, 32'hDEAD_BEEF, 1, 1);
    vecs[2] = mk(0, 1, 0, 32'h0, 32'h1111_1111, 7, 1, 0, 32'h0, 32'h2222_2222, 7,
                 5, 7, 9, 3, 32'h1111_1111, 32'h2222_2222, 0, 1);
    vecs[3] = mk(0, 1, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 1, 32'hBAD0_BAD0, 32'h0, 9,
                 0, 7, 9, 5, 32'hFFFF_FFFF, 32'hBAD0_BAD0, 0, 0);
    vecs[4] = mk(0, 1, 0, 32'h0, 32'h0000_0055, 4, 0, 0, 32'h0, 32'h0, 0,
                 4, 0, 7, 4, 32'h0000_0055, 32'h0, 1, 0);
    vecs[5] = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0,
                 4, 9, 7, 5, 32'h0, 32'h0, 0, 0);
    vecs[6] = mk(1, 1, 1, 32'h66, 32'h0, 11, 1, 1, 32'h77, 32'h0, 10,
                 10, 11, 7, 4, 32'h66, 32'h77, 0, 0);
    vecs[7] = mk(0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0,
                 5, 9, 7, 4, 32'h0, 32'h0, 0, 0);
    vecs[8] = mk(0, 1, 0, 32'h0, 32'h12, 12, 1, 1, 32'h34, 32'h0, 13,
                 12, 13, 12, 13, 32'h12, 32'h34, 1, 1);

    resetWB = 1'b1;
    REG_WR1 = 0; DIR_WB1 = 0; DO_wb1 = '0; DIR_wb1 = '0; Y_MUX_wb1 = '0;
    REG_WR2 = 0; DIR_WB2 = 0; DO_wb2 = '0; DIR_wb2 = '0; Y_MUX_wb2 = '0;
    RS1 = '0; RT1 = '0; RS2 = '0; RT2 = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    @(posedge reloj);
    @(negedge reloj);
    resetWB = 1'b0;

    for (int a = 0; a < 32; a++) begin
      @(negedge reloj);
      RS1 = 5'(a); RT1 = 5'(a); RS2 = 5'(a); RT2 = 5'(31 - a);
      #2;
      chk("post-reset RD_RS1", RD_RS1, 32'd0);
      chk("post-reset RD_RT1", RD_RT1, 32'd0);
      chk("post-reset RD_RS2", RD_RS2, 32'd0);
      chk("post-reset RD_RT2", RD_RT2, 32'd0);
    end

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Write to r4 then read it back: stored value must match on the next cycle.
    begin
      vec_t v;
      v = mk(0, 1, 0, 32'h0, 32'h0000_0099, 4, 0, 0, 32'h0, 32'h0, 0,
             4, 4, 4, 4, 32'h0000_0099, 32'h0, 1, 0);
      apply(v, "bypass-w");
      @(negedge reloj);
      REG_WR1 = 0; REG_WR2 = 0; RT2 = 5'd4;
      #2;
      chk("bypass-next RD_RT2", RD_RT2, 32'h0000_0099);
    end

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.rst   = ($urandom_range(0, 15) == 0);
      v.wr1   = $urandom_range(0, 1) == 1;
      v.sel1  = $urandom_range(0, 1) == 1;
      v.mdat1 = $urandom;
      v.alu1  = $urandom;
      v.d1    = 5'($urandom_range(0, 7));
      v.wr2   = $urandom_range(0, 1) == 1;
      v.sel2  = $urandom_range(0, 1) == 1;
      v.mdat2 = $urandom;
      v.alu2  = $urandom;
      v.d2    = 5'($urandom_range(0, 7));
      v.rs1   = 5'($urandom_range(0, 7));
      v.rt1   = 5'($urandom_range(0, 7));
      v.rs2   = 5'($urandom_range(0, 31));
      v.rt2   = 5'($urandom_range(0, 7));
      v = calc(v);
      apply(v, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_dual.md
Name: wb_regfile_dual

Overview:
- Write-back stage and architectural register file for the dual-issue pipeline; the consumer end of the MEM/WB pipeline register outputs.
- Per slot, selects between load data and ALU result and commits it to a 32x32 register file on the clock edge.
- Serves four combinational read ports (rs/rt per slot) to the decode stage.
- Exports the selected write-back values so EX-stage forwarding can use them.

Parameters:
- DATA_W, 32, register and data width.
- NREG, 32, number of architectural registers.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W == NREG.

Ports:
- reloj  input  1  system clock, all state updates on its rising edge.
- resetWB  input  1  synchronous, active-high reset.
- DIR_WB1, DIR_WB2  input  1  per slot write-back select: 1 = memory data DO_wb, 0 = ALU result DIR_wb.
- REG_WR1, REG_WR2  input  1  per slot register write enable.
- DO_wb1, DO_wb2  input  DATA_W  data-memory read data from MEM/WB.
- DIR_wb1, DIR_wb2  input  DATA_W  ALU result from MEM/WB.
- Y_MUX_wb1, Y_MUX_wb2  input  ADDR_W  destination register index.
- RS1, RT1, RS2, RT2  input  ADDR_W  read addresses (slot 1 rs/rt, slot 2 rs/rt).
- RD_RS1, RD_RT1, RD_RS2, RD_RT2  output  DATA_W  read data.
- WD1, WD2  output  DATA_W  selected write-back value per slot (combinational), for forwarding.
- WE1_eff, WE2_eff  output  1  effective write enable per slot, after r0 and conflict masking.

Behaviour:
- Write data selection: WDn = DIR_WBn ? DO_wbn : DIR_wbn. Purely combinational.
- WEn_eff = REG_WRn && (Y_MUX_wbn != 0) && !resetWB.
- Conflict masking: when both slots are enabled to the same nonzero destination, slot 2 (the younger instruction) wins and WE1_eff = 0.
- Commit: on posedge reloj, regs[Y_MUX_wbn] <= WDn for each slot with WEn_eff = 1. Two distinct destinations are written in the same cycle.
- r0 is hardwired to zero: never written, and always reads as 0.
- Reads: asynchronous. RD_x = (addr == 0) ? 0 : regs[addr]. Without bypass, a write becomes visible the cycle after its edge.
- Reset: while resetWB is high at a posedge, all regs are cleared to 0 and all writes that cycle are dropped.
  - Read outputs therefore show 0 from the cycle after the reset edge.
  - WD1/WD2 stay combinational and are unaffected by reset.
- Reset mid-operation behaves identically; there is no pending state beyond the register array.
- X-safety: when REG_WRn = 0, DO_wbn, DIR_wbn and Y_MUX_wbn are don't-care and must not alter state.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: internal write-through. Any read address matching an effective write this cycle returns the corresponding WDn in the same cycle.
  - Slot 2 has priority over slot 1 on a match.
  - r0 still reads 0.
- Undefined: reads return stored contents only; the hazard unit must stall one cycle for a read-after-write at distance 3.

Decomposition:
- Shared package holds DATA_W, NREG and ADDR_W defaults, the REG_ZERO constant (0), and the select encodings WB_SEL_MEM = 1 and WB_SEL_ALU = 0.
- One natural sub-module, wb_sel_slot: per-slot data mux plus effective-enable computation, instantiated twice with the conflict mask applied at the top level.
- The register array and read/bypass logic stay in the top module.

Test Plan:
- Reset then read: assert resetWB for 1 cycle -> RD_RS1, RD_RT1, RD_RS2 and RD_RT2 all read 0 for addresses 0..31.
- Dual write, distinct destinations: slot 1 REG_WR1=1, DIR_WB1=0, DIR_wb1=0x0000_1234, dest 5; slot 2 REG_WR2=1, DIR_WB2=1, DO_wb2=0xDEAD_BEEF, dest 9.
  - Next cycle: RS1=5 reads 0x0000_1234 and RT2=9 reads 0xDEAD_BEEF.
- Same-destination conflict: both slots write dest 7, slot 1 = 0x1111_1111, slot 2 = 0x2222_2222.
  - WE1_eff = 0; register 7 reads 0x2222_2222 next cycle.
- r0 protection: REG_WR1=1, dest 0, data 0xFFFF_FFFF -> WE1_eff = 0 and RS1=0 reads 0.
- Reset during write: resetWB=1 with a write of 0xABCD to reg 3 -> reg 3 reads 0 next cycle.
- Bypass (WB_BYPASS_EN defined): slot 1 writes 0x55 to reg 4 while RT2=4 in the same cycle -> RD_RT2 = 0x55 immediately.
  - Without the macro, RD_RT2 shows the old value and shows 0x55 on the next cycle.
